jk_cmd_seq: RTL

Command sequencer that sits directly upstream of a WIDTH-wide bank of J-K flip-flops and drives their J/K inputs.
- Accepts set/reset/toggle/hold commands over a valid/ready handshake.
- Buffers them in a small FIFO.
- Drives each command onto the J/K lines for a programmable number of clock cycles, back-to-back, with no gaps between commands.
- Output encoding matches J-K semantics directly: J,K = 01 reset, 10 set, 11 toggle, 00 hold.

---
 rtl/jk_cmd_seq.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/jk_cmd_seq.sv
// jk_cmd_seq: command sequencer driving the J/K inputs of a WIDTH-wide J-K
// flip-flop bank. Commands {op, mask, rep} arrive over valid/ready, are
// buffered in a DEPTH-entry FIFO and each is driven for rep+1 cycles,
// back-to-back with no gap between commands.
//
// Ports:
//   clk        clock, all state updates on posedge
//   Clear      synchronous active-high reset (overrides everything)
//   abort      (only with JKSEQ_ABORT_EN) flush queue, return to idle, no done
//   cmd_valid  command present
//   cmd_ready  FIFO not full (combinational from FIFO count)
//   cmd_op     {J,K}: 00 hold, 01 reset, 10 set, 11 toggle
//   cmd_mask   flip-flops affected; unmasked bits get J=K=0
//   cmd_rep    command is issued for cmd_rep+1 consecutive cycles
//   J, K       registered J/K drive
//   busy       FIFO non-empty or a command is issuing (combinational)
//   done       registered, high in the final issue cycle of each command
//
// Optional feature macro: JKSEQ_ABORT_EN (adds the abort input).
module jk_cmd_seq #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             Clear,
`ifdef JKSEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [CNT_W-1:0] cmd_rep,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             busy,
    output logic             done
);

    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FCNT_W  = PTR_W + 1;
    localparam int unsigned ENTRY_W = 2 + WIDTH + CNT_W;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   j_q, j_d;
    logic [WIDTH-1:0]   k_q, k_d;
    logic               done_q, done_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic               abort_w;
    logic               full, empty, push, pop;
    logic [ENTRY_W-1:0] head;
    logic [1:0]         head_op;
    logic [WIDTH-1:0]   head_mask;
    logic [CNT_W-1:0]   head_rep;

`ifdef JKSEQ_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign full      = (fcnt_q == FCNT_W'(DEPTH));
    assign empty     = (fcnt_q == '0);
    assign cmd_ready = !full;
    // An abort cycle refuses the presented command even though ready may be high.
    assign push      = cmd_valid && !full && !abort_w;
    assign busy      = (state_q == ISSUE) || !empty;

    assign head      = mem_q[rd_ptr_q];
    assign head_op   = head[ENTRY_W-1 -: 2];
    assign head_mask = head[CNT_W +: WIDTH];
    assign head_rep  = head[CNT_W-1:0];

    assign J    = j_q;
    assign K    = k_q;
    assign done = done_q;

    // FIFO storage; contents need no reset since pointers/count gate reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_op, cmd_mask, cmd_rep};
        end
    end

    // Next-state: sequencer FSM, issue counter, J/K drive and FIFO bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        j_d     = j_q;
        k_d     = k_q;
        pop     = 1'b0;

        unique case (state_q)
            IDLE: begin
                j_d = '0;
                k_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    j_d     = head_mask & {WIDTH{head_op[1]}};
                    k_d     = head_mask & {WIDTH{head_op[0]}};
                    cnt_d   = head_rep;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!empty) begin
                    // Zero-gap handoff to the next queued command.
                    pop   = 1'b1;
                    j_d   = head_mask & {WIDTH{head_op[1]}};
                    k_d   = head_mask & {WIDTH{head_op[0]}};
                    cnt_d = head_rep;
                end else begin
                    j_d     = '0;
                    k_d     = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // done is registered: it marks the cycle whose count is zero while issuing.
        done_d   = (state_d == ISSUE) && (cnt_d == '0);

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        fcnt_d   = fcnt_q + FCNT_W'(push) - FCNT_W'(pop);

        if (abort_w) begin
            state_d  = IDLE;
            cnt_d    = '0;
            j_d      = '0;
            k_d      = '0;
            done_d   = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fcnt_d   = '0;
        end
    end

    // State registers with synchronous Clear.
    always_ff @(posedge clk) begin
        if (Clear) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
            cnt_q    <= '0;
            j_q      <= '0;
            k_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fcnt_q   <= fcnt_d;
            cnt_q    <= cnt_d;
            j_q      <= j_d;
            k_q      <= k_d;
            done_q   <= done_d;
        end
    end

endmodule
